// File: rtl/ase_fifo_drain_pkg.sv
// Shared definitions for the ASE FIFO stream drain: error-flag bit positions,
// the sticky error vector type and the saturating counter helper.
package ase_fifo_drain_pkg;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_LOST      = 1;
    localparam int ERR_SPURIOUS  = 2;

    // Widest counter sat_inc can handle.
    localparam int SAT_MAX_WIDTH = 64;

    typedef logic [2:0] ase_drain_err_t;

    // Increment, holding at all-ones of the given width; callers zero-extend and slice back.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
        input logic [SAT_MAX_WIDTH-1:0] value,
        input int unsigned              width
    );
        logic [SAT_MAX_WIDTH-1:0] max_val;
        if (width >= SAT_MAX_WIDTH) begin
            max_val = '1;
        end else begin
            max_val = (SAT_MAX_WIDTH'(1) << width) - SAT_MAX_WIDTH'(1);
        end
        return (value == max_val) ? value : value + SAT_MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ase_skid_ring.sv
// Small circular buffer holding beats between the FIFO pop and the stream output.
// Head is read straight from the entry array so a beat pushed in cycle N is visible in N+1.
module ase_skid_ring #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     occ,
    output logic [DATA_WIDTH-1:0]      head
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

    // The issue logic upstream must never let the ring overflow or pop while empty.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && occ_q == OW'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst) !(pop && occ_q == '0));

endmodule

// File: rtl/ase_fifo_stream_drain.sv
// Drains the 1-cycle-latency ASE FIFO read port into a valid/ready stream with
// sequence tags, saturating beat/stall statistics and sticky protocol-error flags.
module ase_fifo_stream_drain
    import ase_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int SKID_DEPTH = 2,
    parameter int SEQ_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_data_v,
    input  logic                          fifo_underflow,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SEQ_WIDTH-1:0]          out_seq,
    output logic [$clog2(SKID_DEPTH):0]   skid_occ,
    output logic [CNT_WIDTH-1:0]          beat_count,
    output logic [CNT_WIDTH-1:0]          stall_count,
    output logic [2:0]                    err_flags
);
    localparam int OW = $clog2(SKID_DEPTH) + 1;

    logic                 inflight_q, inflight_d;
    logic                 rst_d_q, rst_d_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    ase_drain_err_t       err_q, err_d;

    logic                     pop;
    logic                     push;
    logic [OW:0]              demand;
    logic [SAT_MAX_WIDTH-1:0] beat_inc;
    logic [SAT_MAX_WIDTH-1:0] stall_inc;

    assign out_valid = (skid_occ != '0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && fifo_data_v;

    // Slots already spoken for once this cycle's pop leaves; pop implies occ >= 1, so no wrap.
    assign demand     = {1'b0, skid_occ} + (OW+1)'(inflight_q) - (OW+1)'(pop);
    assign fifo_rd_en = !rst && !fifo_empty && (demand < (OW+1)'(SKID_DEPTH));

    ase_skid_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (skid_occ),
        .head      (out_data)
    );

    always_comb begin
        inflight_d    = fifo_rd_en;
        rst_d_d       = 1'b0;
        seq_d         = seq_q;
        beat_count_d  = beat_count_q;
        stall_count_d = stall_count_q;
        err_d         = err_q;
        beat_inc      = sat_inc(SAT_MAX_WIDTH'(beat_count_q), CNT_WIDTH);
        stall_inc     = sat_inc(SAT_MAX_WIDTH'(stall_count_q), CNT_WIDTH);

        if (pop) begin
            seq_d        = seq_q + SEQ_WIDTH'(1);
            beat_count_d = beat_inc[CNT_WIDTH-1:0];
        end
        if (out_valid && !out_ready) begin
            stall_count_d = stall_inc[CNT_WIDTH-1:0];
        end

        if (fifo_underflow) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
        end
        if (inflight_q && !fifo_data_v) begin
            err_d[ERR_LOST] = 1'b1;
        end
        // A response to a read issued before reset shows up right after it; drop that one quietly.
        if (!inflight_q && fifo_data_v && !rst_d_q) begin
            err_d[ERR_SPURIOUS] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q    <= 1'b0;
            rst_d_q       <= 1'b1;
            seq_q         <= '0;
            beat_count_q  <= '0;
            stall_count_q <= '0;
            err_q         <= '0;
        end else begin
            inflight_q    <= inflight_d;
            rst_d_q       <= rst_d_d;
            seq_q         <= seq_d;
            beat_count_q  <= beat_count_d;
            stall_count_q <= stall_count_d;
            err_q         <= err_d;
        end
    end

    assign out_seq     = seq_q;
    assign beat_count  = beat_count_q;
    assign stall_count = stall_count_q;
    assign err_flags   = err_q;

endmodule
